// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM period/on-time decoder with stuck detection; optional filter via PWM_DECODER_GLITCH_FILTER_EN
module pwm_decoder #(
   parameter int MAIN_FREQ     = 50000000,
   parameter int SAMPLE_FREQ   = 200000,
   parameter int CNT_W         = 16,
   parameter int TIMEOUT_TICKS = 1024
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);

   localparam int DIV = MAIN_FREQ / SAMPLE_FREQ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    DIV_LAST = PW'(DIV - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [CNT_W-1:0] TO_FULL  = CNT_W'(TIMEOUT_TICKS);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

   logic             sync_meta;
   logic             sync_in;
   logic [PW-1:0]    presc;
   logic             tick;
   logic             lvl;
   logic             prev;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] per_acc;
   logic [CNT_W-1:0] hi_acc;
   state_t           state;
   state_t           state_nxt;
   logic             publish;
   logic             timeout;

   // Two-flop synchronizer for the asynchronous pin
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_in   <= 1'b0;
      end else begin
         sync_meta <= pwm_in;
         sync_in   <= sync_meta;
      end
   end

   // Prescaler: tick pulses on the last count of each DIV-cycle window
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   assign tick = (presc == DIV_LAST);

`ifdef PWM_DECODER_GLITCH_FILTER_EN
   logic [1:0] hist;

   // Filtered sampler: lvl moves only after three equal consecutive samples
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         hist <= 2'b00;
         lvl  <= 1'b0;
         prev <= 1'b0;
      end else if (tick) begin
         hist <= {hist[0], sync_in};
         prev <= lvl;
         if (sync_in == hist[0] && sync_in == hist[1])
            lvl <= sync_in;
      end
   end
`else
   // Raw sampler: lvl is the synchronized input taken on each tick
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         lvl  <= 1'b0;
         prev <= 1'b0;
      end else if (tick) begin
         lvl  <= sync_in;
         prev <= lvl;
      end
   end
`endif

   assign rise = tick & lvl & ~prev;
   assign fall = tick & ~lvl & prev;

   // State register
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state plus publish/timeout decisions; rise beats timeout
   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      timeout   = 1'b0;
      if (state != STUCK && tick && !rise && per_acc == TO_LAST) begin
         timeout   = 1'b1;
         state_nxt = STUCK;
      end else begin
         case (state)
            IDLE:  if (rise) state_nxt = HIGH;
            HIGH:  if (fall) state_nxt = LOW;
            LOW:   if (rise) begin
                      publish   = 1'b1;
                      state_nxt = HIGH;
                   end
            STUCK: if (rise) state_nxt = HIGH;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Accumulators and published outputs; per_acc freezes once stuck
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         per_acc     <= '0;
         hi_acc      <= '0;
         high_cnt    <= '0;
         period_cnt  <= '0;
         valid       <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (rise) begin
            per_acc <= CNT_W'(1);
            hi_acc  <= CNT_W'(1);
         end else if (tick) begin
            if (state != STUCK && !timeout)
               per_acc <= per_acc + CNT_W'(1);
            if (lvl)
               hi_acc <= hi_acc + CNT_W'(1);
         end
         if (publish) begin
            high_cnt   <= hi_acc;
            period_cnt <= per_acc;
            valid      <= 1'b1;
         end else if (timeout) begin
            high_cnt    <= lvl ? TO_FULL : '0;
            period_cnt  <= TO_FULL;
            valid       <= 1'b1;
            stuck       <= 1'b1;
            stuck_level <= lvl;
         end else if (state == STUCK) begin
            if (rise) begin
               stuck       <= 1'b0;
               stuck_level <= 1'b0;
            end else if (tick) begin
               stuck_level <= lvl;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed self-checking bench for pwm_decoder
module tb_pwm_decoder;

   localparam int DIV   = 4;
   localparam int CNT_W = 16;

   logic             CLOCK_50 = 1'b0;
   logic             reset    = 1'b0;
   logic             pwm_in   = 1'b0;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             valid;
   logic             stuck;
   logic             stuck_level;

   int               n_checks = 0;
   int               n_fail   = 0;
   int               vcount   = 0;
   logic [CNT_W-1:0] pub_hi  [0:7];
   logic [CNT_W-1:0] pub_per [0:7];
   logic             last_valid = 1'b0;
   logic             dbl        = 1'b0;

   pwm_decoder #(
      .MAIN_FREQ     (50000000),
      .SAMPLE_FREQ   (12500000),
      .CNT_W         (CNT_W),
      .TIMEOUT_TICKS (1024)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .pwm_in      (pwm_in),
      .high_cnt    (high_cnt),
      .period_cnt  (period_cnt),
      .valid       (valid),
      .stuck       (stuck),
      .stuck_level (stuck_level)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Publish monitor: counts valid pulses, records values, flags back-to-back strobes
   always @(negedge CLOCK_50) begin
      if (reset) begin
         vcount = 0;
      end else if (valid) begin
         if (vcount < 8) begin
            pub_hi[vcount]  = high_cnt;
            pub_per[vcount] = period_cnt;
         end
         vcount = vcount + 1;
         if (last_valid) dbl = 1'b1;
      end
      last_valid = valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * DIV) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic pwm_period(input int hi, input int per);
      pwm_in = 1'b1;
      wait_ticks(hi);
      pwm_in = 1'b0;
      wait_ticks(per - hi);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset  = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      // asynchronous reset before any clock edge
      #3 reset = 1'b1;
      #1;
      check("rst_high_cnt", high_cnt, 0);
      check("rst_period_cnt", period_cnt, 0);
      check("rst_valid", valid, 0);
      check("rst_stuck", stuck, 0);
      check("rst_stuck_level", stuck_level, 0);
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;

      wait_ticks(300);
      check("idle_no_valid", vcount, 0);

      // 25% duty, four periods: rises 2..4 publish
      repeat (4) pwm_period(50, 200);
      check("d25_count", vcount, 3);
      check("d25_first_hi", pub_hi[0], 50);
      check("d25_first_per", pub_per[0], 200);
      check("d25_high_cnt", high_cnt, 50);
      check("d25_period_cnt", period_cnt, 200);
      check("d25_not_stuck", stuck, 0);

      // reset in the middle of a high phase
      pwm_in = 1'b1;
      wait_ticks(20);
      #5 reset = 1'b1;
      #1;
      check("midrst_high_cnt", high_cnt, 0);
      check("midrst_period_cnt", period_cnt, 0);
      check("midrst_valid", valid, 0);
      pwm_in = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      wait_ticks(10);
      pwm_in = 1'b1;
      wait_ticks(5);
      check("midrst_first_rise", vcount, 0);
      wait_ticks(65);
      pwm_in = 1'b0;
      wait_ticks(130);
      pwm_in = 1'b1;
      wait_ticks(5);
      check("midrst_count", vcount, 1);
      check("midrst_hi", high_cnt, 70);
      check("midrst_per", period_cnt, 200);

      // stuck low from reset
      do_reset();
      wait_ticks(1000);
      check("sl_pre_count", vcount, 0);
      check("sl_pre_stuck", stuck, 0);
      wait_ticks(40);
      check("sl_stuck", stuck, 1);
      check("sl_level", stuck_level, 0);
      check("sl_high_cnt", high_cnt, 0);
      check("sl_period_cnt", period_cnt, 1024);
      check("sl_count", vcount, 1);
      wait_ticks(600);
      check("sl_no_more_valid", vcount, 1);

      // stuck high, then recovery
      do_reset();
      pwm_in = 1'b1;
      wait_ticks(1040);
      check("sh_stuck", stuck, 1);
      check("sh_level", stuck_level, 1);
      check("sh_high_cnt", high_cnt, 1024);
      check("sh_period_cnt", period_cnt, 1024);
      check("sh_count", vcount, 1);
      pwm_in = 1'b0;
      wait_ticks(100);
      check("sh_fall_stuck", stuck, 1);
      check("sh_fall_level", stuck_level, 0);
      pwm_period(100, 200);
      check("sh_recovered", stuck, 0);
      pwm_in = 1'b1;
      wait_ticks(5);
      check("sh_rec_count", vcount, 2);
      check("sh_rec_hi", high_cnt, 100);
      check("sh_rec_per", period_cnt, 200);

      // 2-tick low glitch inside a 120-tick high phase
      do_reset();
      wait_ticks(10);
      pwm_period(120, 200);
      pwm_in = 1'b1;
      wait_ticks(59);
      pwm_in = 1'b0;
      wait_ticks(2);
      pwm_in = 1'b1;
      wait_ticks(59);
      pwm_in = 1'b0;
      wait_ticks(80);
      pwm_in = 1'b1;
      wait_ticks(5);
      check("gl_clean_hi", pub_hi[0], 120);
      check("gl_clean_per", pub_per[0], 200);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      check("gl_count", vcount, 2);
      check("gl_hi", pub_hi[1], 120);
      check("gl_per", pub_per[1], 200);
`else
      check("gl_count", vcount, 3);
      check("gl_short_hi", pub_hi[1], 59);
      check("gl_short_per", pub_per[1], 61);
      check("gl_tail_hi", high_cnt, 59);
      check("gl_tail_per", period_cnt, 139);
`endif

      check("no_double_valid", dbl, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart to the on-board PWM LED generators. Samples an external PWM signal on a 50 MHz clock, resolves each period into on-time and period counts in sample ticks, and reports stuck-high or stuck-low inputs. Sits between a board input pin and any logic that regenerates, checks or displays a received brightness value in the same tick units as the LED PWM.

## Interface

Parameters:
- MAIN_FREQ, 50000000: CLOCK_50 frequency in Hz.
- SAMPLE_FREQ, 200000: sample tick rate in Hz. This is PWM_FREQ 1000 × 200 samples, so one 1 kHz PWM period measures as 200 ticks.
- CNT_W, 16: width of the count outputs and internal accumulators.
- TIMEOUT_TICKS, 1024: number of ticks with no rising edge before the input is declared stuck. Must be less than 2^CNT_W.

Ports:
- CLOCK_50, input, 1: system clock. Single clock domain.
- reset, input, 1: asynchronous reset, active-high.
- pwm_in, input, 1: asynchronous PWM input from the pin.
- high_cnt, output, CNT_W: on-time of the last completed period, in ticks.
- period_cnt, output, CNT_W: length of the last completed period, in ticks.
- valid, output, 1: one-cycle strobe. Asserts when high_cnt and period_cnt update.
- stuck, output, 1: input has had no rising edge for TIMEOUT_TICKS ticks.
- stuck_level, output, 1: sampled level of the input while stuck is asserted.

## Operation

Front end:
- pwm_in passes through a 2-FF synchronizer into sync_in.
- A prescaler generates tick, a one-cycle pulse every DIV = MAIN_FREQ/SAMPLE_FREQ cycles (250 at default parameters). The prescaler counts 0..DIV-1 and tick fires on DIV-1.
- On each tick, lvl <= sync_in and prev <= lvl.
- rise = tick & lvl & !prev. fall = tick & !lvl & prev.

Accumulators (CNT_W bits each):
- per_acc: on rise, loads 1. On any other tick, increments.
- hi_acc: on rise, loads 1. On any other tick with lvl=1, increments.

States:
- IDLE: reset state. Waiting for the first rising edge.
  - rise → HIGH, no publish.
  - fall → stays in IDLE.
- HIGH:
  - fall → LOW.
- LOW:
  - rise → publish, then HIGH.
- STUCK:
  - rise → HIGH, clear stuck, no publish.

Publish action:
- high_cnt <= hi_acc, period_cnt <= per_acc. These are the pre-reload values.
- Pulse valid.

Timeout:
- Applies in IDLE, HIGH and LOW.
- Condition: a tick with no rise and per_acc = TIMEOUT_TICKS-1.
- Enter STUCK. Set stuck=1 and stuck_level=lvl.
- Publish high_cnt = lvl ? TIMEOUT_TICKS : 0 and period_cnt = TIMEOUT_TICKS, with a valid pulse.
- In STUCK, per_acc is held, so no further timeout publishes occur. stuck_level tracks lvl.
- A fall while in STUCK only updates stuck_level.

Simultaneous events:
- rise has priority over timeout on the same tick.

Reset values:
- high_cnt=0, period_cnt=0, valid=0, stuck=0, stuck_level=0.
- State IDLE. Accumulators, prescaler, synchronizer, lvl and prev all 0.
- Reset asserted mid-period discards the partial measurement. The first rise after reset never publishes.

## Timing

- pwm_in to lvl: 2 clock cycles of synchronizer, plus up to DIV cycles of sampling quantization.
- valid asserts in the cycle after the rise tick. high_cnt and period_cnt change in that same cycle and hold until the next publish.
- valid is never asserted for two consecutive cycles.
- Measurement resolution: ±1 tick per edge.
- Minimum measurable high or low phase: 1 tick. Shorter pulses may be missed.

## Configuration

Macro: PWM_DECODER_GLITCH_FILTER_EN.

Defined:
- lvl changes only after sync_in has held its new value on 3 consecutive ticks.
- Both edges are delayed by 2 ticks, so high_cnt and period_cnt are unchanged for clean inputs.
- Pulses of 2 ticks or fewer are rejected.

Undefined:
- lvl is the raw tick sample of sync_in.
- No filter logic is synthesized.

## Test plan

- **Reset state:** assert reset asynchronously with no clock edge → all outputs 0 immediately. Release reset and hold pwm_in=0 → no valid pulse until the timeout.
- **25% duty:** 1 kHz PWM, 50 ticks high, 150 ticks low, three periods → first rise gives no publish. Then high_cnt=50, period_cnt=200 with exactly one valid pulse per period.
- **Stuck low:** pwm_in held 0 from reset → after 1024 ticks, stuck=1, stuck_level=0, high_cnt=0, period_cnt=1024, one valid pulse. No further valid pulses.
- **Stuck high, then recovery:** pwm_in held 1 → stuck=1, stuck_level=1, high_cnt=1024. Resume a 100/200 PWM → stuck clears on the first rise. Next valid reports 100/200.
- **Reset mid-operation:** assert reset during the HIGH phase → outputs return to 0 and state to IDLE. The following first period is not published.
- **Glitch filter (macro defined):** a 2-tick low glitch inside a 120-tick high phase → high_cnt=120, period_cnt=200. With the macro undefined, the same stimulus publishes a short period at the glitch's rising edge.
